// File: rtl/board_timer_pkg.sv
// Shared constants and helpers for the board timer bank.
package board_timer_pkg;

  localparam int unsigned N_CH_DEF  = 9;
  localparam int unsigned WIDTH_DEF = 28;
  // The last channel is reserved for round/game timing.
  localparam int unsigned ROUND_CH  = N_CH_DEF - 1;

  // Index width for an encoded channel number; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_timer_bank_if.sv
// Control and status bundle between the board FSM and the timer bank.
interface board_timer_bank_if
  import board_timer_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = idx_width(N_CH)
) ();

  logic                  tick_en;
  logic [N_CH-1:0]       load;
  logic [N_CH*WIDTH-1:0] loadval;
  logic [N_CH-1:0]       auto_reload;
  logic [N_CH-1:0]       cancel;
  logic [N_CH-1:0]       active;
  logic [N_CH-1:0]       expired;
  logic                  expired_any;
  logic [IDX_W-1:0]      expired_idx;

  modport master (
    output tick_en, load, loadval, auto_reload, cancel,
    input  active, expired, expired_any, expired_idx
  );

  modport slave (
    input  tick_en, load, loadval, auto_reload, cancel,
    output active, expired, expired_any, expired_idx
  );

endinterface

// File: rtl/board_timer_ch.sv
// One countdown channel: counter, reload value, mode and running flag.
// fire is the combinational expiry decision for the coming edge.
module board_timer_ch
  import board_timer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic             load,
  input  logic [WIDTH-1:0] loadval,
  input  logic             auto_reload,
  input  logic             cancel,
  output logic             active,
  output logic             fire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             active_q, active_d;

  // Cancel and load both pre-empt an expiry on the same edge.
  assign fire   = active_q & tick_en & (cnt_q == '0) & ~cancel & ~load;
  assign active = active_q;

  // Next-state: cancel > load > expiry > decrement > hold.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    active_d = active_q;
    if (cancel) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (load) begin
      cnt_d    = loadval;
      reload_d = loadval;
      mode_d   = auto_reload;
      active_d = 1'b1;
    end else if (fire) begin
      if (mode_q) begin
        cnt_d = reload_q;
      end else begin
        active_d = 1'b0;
      end
    end else if (active_q && tick_en) begin
      // Zero is always caught as expiry above, so this never wraps.
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/board_timer_bank.sv
// Bank of independent countdown channels with registered expiry pulses
// and a lowest-index encoder for the board FSM.
module board_timer_bank
  import board_timer_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = idx_width(N_CH)
) (
  input logic               clk,
  input logic               rst_n,
  board_timer_bank_if.slave bus
);

  logic [N_CH-1:0]  fire;
  logic [N_CH-1:0]  active_w;
  logic [IDX_W-1:0] idx_d;
  logic [N_CH-1:0]  expired_q;
  logic             any_q;
  logic [IDX_W-1:0] idx_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    board_timer_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_en     (bus.tick_en),
      .load        (bus.load[i]),
      .loadval     (bus.loadval[i*WIDTH +: WIDTH]),
      .auto_reload (bus.auto_reload[i]),
      .cancel      (bus.cancel[i]),
      .active      (active_w[i]),
      .fire        (fire[i])
    );
  end

  // Lowest set bit of the fire vector wins; descending scan lets it overwrite last.
  always_comb begin
    idx_d = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (fire[i]) idx_d = IDX_W'(i);
    end
  end

  // Pulse, any and index all register from the same fire vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired_q <= '0;
      any_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      expired_q <= fire;
      any_q     <= |fire;
      idx_q     <= idx_d;
    end
  end

  assign bus.active      = active_w;
  assign bus.expired     = expired_q;
  assign bus.expired_any = any_q;
  assign bus.expired_idx = idx_q;

endmodule

// File: doc/board_timer_bank.md
Name: board_timer_bank

Overview:
- Multi-channel countdown timer bank for the board state machine. One independent channel per mole hole, plus a spare for round/game timing.
- Generalises the single-channel board timer: parametrised channel count and width, per-channel one-shot or auto-reload mode, global pause, per-channel cancel.
- Outputs are one-cycle expiry pulses plus an encoded "lowest expired channel" for the board FSM.

Parameters:
- N_CH, 9, number of independent timer channels (>=1)
- WIDTH, 28, counter width in bits; time = (loadval+1) clk cycles
- IDX_W, $clog2(N_CH) (min 1), width of expired_idx

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- tick_en  input  1  global count enable; low = pause all channels (load/cancel still honoured)
- load  input  N_CH  per-channel load strobe, active high
- loadval  input  N_CH*WIDTH  per-channel load value, channel i in bits [i*WIDTH +: WIDTH]
- auto_reload  input  N_CH  per-channel mode, sampled with load: 1 = periodic, 0 = one-shot
- cancel  input  N_CH  per-channel stop, active high, no expiry pulse
- active  output  N_CH  channel i is running or paused with time pending
- expired  output  N_CH  one-cycle pulse per expiry, registered
- expired_any  output  1  OR of expired, same cycle
- expired_idx  output  IDX_W  lowest-index set bit of expired; 0 when none set

Behaviour:
- Reset (async): all counters 0, reload regs 0, mode 0, active 0, expired 0, expired_any 0, expired_idx 0. Idle channels never fire. This deliberately differs from the level trigger of the single timer.
- Per channel i, priority at each edge: cancel > load > expiry > decrement.
- cancel[i]: active<=0, counter<=0, expired[i]<=0. This holds even if the channel would have expired this edge.
- load[i] (no cancel): counter<=V, reload<=V, mode<=auto_reload[i], active<=1, expired[i]<=0.
  - Load on the expiry edge wins; no pulse is emitted.
  - Load is taken regardless of tick_en.
- Expiry: active && tick_en && counter==0 -> expired[i]<=1 for exactly one cycle.
  - One-shot: active<=0.
  - Auto-reload: counter<=reload and active stays 1.
- Decrement: active && tick_en && counter!=0 -> counter<=counter-1.
- Otherwise hold. expired[i]<=0 on any edge that is not an expiry edge.
- Latency: with tick_en held high, expired[i] rises V+1 edges after the edge that sampled load (V=0 -> next edge). Auto-reload period is V+1 cycles, with no gap or extra cycle at reload.
- Pause: tick_en low freezes all counters and suppresses expiry. Resuming continues from the frozen value, so total active edges still equals V+1.
- Width: counter is WIDTH bits unsigned. V = 2^WIDTH-1 must work with no overflow. Decrement never wraps because zero is caught as expiry.
- expired_any and expired_idx are registered from the same next-state vector as expired, so all three change on the same edge. With simultaneous expiries, expired_idx is the lowest index.
- Reset asserted mid-count: all state clears immediately; no pulse on reset release.

Decomposition:
- Package board_timer_pkg: default WIDTH/N_CH constants, and the channel index of the round timer (ROUND_CH = N_CH-1).
- Sub-module board_timer_ch: one channel (counter, reload reg, mode, active, expiry logic). Instantiated N_CH times in a generate loop.
- Top-level board_timer_bank: the lowest-index priority encoder and the output registers.

Test Plan:
- Reset then 20 idle cycles -> active=0, expired=0, expired_any=0 throughout.
- Ch2 load V=5, one-shot, tick_en=1 -> expired[2] high exactly on the 6th edge after load, one cycle only; then active[2]=0.
- Ch0 load V=3, auto_reload=1, run 20 edges -> expired[0] pulses every 4 edges starting on edge 4; active stays 1. Cancel on edge 10 -> no further pulses, active[0]=0.
- Ch1 load V=4, drop tick_en for 7 cycles after edge 2 -> expiry delayed by exactly 7 cycles (edge 12).
- Ch3 and ch5 load V=2 on the same edge -> expired=0b101000, expired_any=1, expired_idx=3 on edge 3.
- Ch4 reload with V=6 on its expiry edge -> no pulse that edge, next pulse 7 edges later. Also load V=2^WIDTH-1 with WIDTH=4 -> pulse after 16 edges. rst_n low mid-count -> all outputs 0 asynchronously.
